// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the calculadora_mc multi-cycle calculator.
//   op_e    - 2-bit operation select (add, sub, mul, div)
//   state_e - control FSM states (idle, iterating, completion pulse)
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: one-bit-per-cycle engine for unsigned shift-add multiply and
// restoring divide. Holds the working pair {hi, lo} and the second operand.
//   clk, rst     - clock, synchronous active-high reset
//   i_load       - capture i_a / i_b / i_div and clear the accumulator
//   i_step       - perform one iteration
//   i_div        - mode captured at load: 1 divide, 0 multiply
//   i_a, i_b     - multiplicand/multiplier or dividend/divisor
//   o_prod_n     - product value that the current step will produce
//   o_quo_n      - quotient value that the current step will produce
//   o_rem_n      - remainder value that the current step will produce
// The "_n" outputs are the post-step values, so the caller can register the
// final result on the same edge as the last iteration.
module mul_div_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_div,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_prod_n,
    output logic [W-1:0]   o_quo_n,
    output logic [W-1:0]   o_rem_n
);

    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_d;
    logic         r_div;

    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_hi_n;
    logic [W-1:0] w_lo_n;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (lo[0]) is set, then shift {carry, hi, lo} right by one.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);

    // Divide: shift the next dividend bit into the partial remainder and keep
    // the trial difference only when it does not go negative. The partial
    // remainder stays below the divisor, so the difference fits in W bits.
    assign w_shift = {r_hi, r_lo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_d});
    assign w_diff  = w_shift[W-1:0] - r_d;

    always_comb begin
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        if (r_div) begin
            w_hi_n = w_ge ? w_diff : w_shift[W-1:0];
            w_lo_n = {r_lo[W-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[W:1];
            w_lo_n = {w_sum[0], r_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_d   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_d   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
        end
    end

    assign o_prod_n = {w_hi_n, w_lo_n};
    assign o_quo_n  = w_lo_n;
    assign o_rem_n  = w_hi_n;

endmodule

// File: rtl/calculadora_mc.sv
// calculadora_mc: W-bit unsigned add/sub/mul/div behind a start/busy/done
// handshake. Add, subtract and divide-by-zero finish straight away; multiply
// and divide run W iterations in mul_div_iter.
//   clk, rst - clock, synchronous active-high reset
//   start    - request, accepted only while idle
//   op       - 00 add, 01 sub, 10 mul, 11 div
//   A, B     - operands (B is the divisor for div)
//   busy     - high in every state except idle
//   done     - one-cycle completion pulse
//   S        - 2W-bit result / quotient, held until the next completion
//   R        - remainder for div, 0 otherwise
//   err      - last operation was a divide by zero
// Handshake: an edge with start=1 while busy=0 accepts the request and
// captures op/A/B; start seen while busy (including the done cycle) is
// dropped. done rises once per accepted request and S/R/err are valid from
// that cycle until the next completion.
module calculadora_mc
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] S,
    output logic [W-1:0]   R,
    output logic           err,
    output state_e         o_state
);

    localparam int CW = $clog2(W + 1);

    state_e         r_state;
    op_e            r_op;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_s;
    logic [W-1:0]   r_r;
    logic           r_err;

    logic           w_accept;
    op_e            w_op;
    logic [W:0]     w_add;
    logic [W:0]     w_sub;
    logic [2*W-1:0] w_prod_n;
    logic [W-1:0]   w_quo_n;
    logic [W-1:0]   w_rem_n;

    assign w_op     = op_e'(op);
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_add    = {1'b0, A} + {1'b0, B};
    // Bit W of the extended difference is the borrow, i.e. the sign.
    assign w_sub    = {1'b0, A} - {1'b0, B};

    mul_div_iter #(.W(W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   (r_state == ST_RUN),
        .i_div    (w_op == OP_DIV),
        .i_a      (A),
        .i_b      (B),
        .o_prod_n (w_prod_n),
        .o_quo_n  (w_quo_n),
        .o_rem_n  (w_rem_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_s     <= '0;
            r_r     <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= w_op;
                        case (w_op)
                            OP_ADD: begin
                                r_s     <= {{(W-1){1'b0}}, w_add};
                                r_r     <= '0;
                                r_err   <= 1'b0;
                                r_state <= ST_DONE;
                            end
                            OP_SUB: begin
                                r_s     <= {{W{w_sub[W]}}, w_sub[W-1:0]};
                                r_r     <= '0;
                                r_err   <= 1'b0;
                                r_state <= ST_DONE;
                            end
                            OP_MUL: begin
                                r_cnt   <= CW'(W);
                                r_state <= ST_RUN;
                            end
                            default: begin
                                if (B == '0) begin
                                    r_s     <= '1;
                                    r_r     <= A;
                                    r_err   <= 1'b1;
                                    r_state <= ST_DONE;
                                end else begin
                                    r_cnt   <= CW'(W);
                                    r_state <= ST_RUN;
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Last iteration: publish the post-step engine values.
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b0;
                        if (r_op == OP_DIV) begin
                            r_s <= {{W{1'b0}}, w_quo_n};
                            r_r <= w_rem_n;
                        end else begin
                            r_s <= w_prod_n;
                            r_r <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign S       = r_s;
    assign R       = r_r;
    assign err     = r_err;
    assign o_state = r_state;

endmodule

// File: tb/tb_calculadora_mc.sv
module tb_calculadora_mc;
  import calc_pkg::*;

  logic clk;
  logic rst;

  // W=8 instance
  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, err8;
  logic [15:0] s8;
  logic [7:0]  r8;
  state_e      st8;

  // W=16 instance
  logic        start16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, err16;
  logic [31:0] s16;
  logic [15:0] r16;
  state_e      st16;

  int n_checks;
  int n_errors;
  int cur_w;

  logic [31:0] t_s;
  logic [15:0] t_r;
  logic        t_done, t_busy, t_err;

  calculadora_mc #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .S(s8), .R(r8), .err(err8), .o_state(st8)
  );

  calculadora_mc #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .S(s16), .R(r16), .err(err16), .o_state(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    t_s = '0; t_r = '0; t_done = 1'b0; t_busy = 1'b0; t_err = 1'b0;
    if (cur_w == 8) begin
      t_s = {16'h0, s8}; t_r = {8'h0, r8};
      t_done = done8; t_busy = busy8; t_err = err8;
    end else begin
      t_s = s16; t_r = r16;
      t_done = done16; t_busy = busy16; t_err = err16;
    end
  end

  // scoreboard of expected completions
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; op16 = op; a16 = a; b16 = b;
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after a posedge, idle.
  task automatic run_op(input int w, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] es, input logic [15:0] er,
                        input logic eerr, input int elat, input logic hold, input string tag);
    int lat;
    logic [31:0] exp_s;
    cur_w = w;
    exp_q.push_back(es);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, {31'b0, t_busy}, 32'd1);
    drive(w, hold, ~op, 16'($urandom), 16'($urandom));
    lat = 1;
    while (!t_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (hold) drive(w, 1'b1, op, 16'($urandom), 16'($urandom));
    end
    exp_s = exp_q.pop_front();
    check({tag, " latency"}, lat, elat);
    check({tag, " S"}, t_s, exp_s);
    check({tag, " R"}, {16'b0, t_r}, {16'b0, er});
    check({tag, " err"}, {31'b0, t_err}, {31'b0, eerr});
    @(posedge clk); #1;
    check({tag, " busy_after_done"}, {31'b0, t_busy}, 32'd0);
    check({tag, " done_pulse_len"}, {31'b0, t_done}, 32'd0);
    drive(w, 1'b0, 2'b00, 16'h0, 16'h0);
  endtask

  initial begin
    int rlat;
    logic seen_done;
    logic [1:0] rop;
    logic [15:0] ra, rb;
    logic [16:0] rd;
    logic [31:0] rs;
    logic [15:0] rr;
    logic rerr;
    n_checks = 0;
    n_errors = 0;
    cur_w = 8;
    rst = 1'b1;
    drive(8, 1'b0, 2'b00, 16'h0, 16'h0);
    drive(16, 1'b0, 2'b00, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst busy8", {31'b0, busy8}, 32'd0);
    check("rst done8", {31'b0, done8}, 32'd0);
    check("rst S8", {16'b0, s8}, 32'd0);
    check("rst R8", {24'b0, r8}, 32'd0);
    check("rst err8", {31'b0, err8}, 32'd0);
    check("rst S16", s16, 32'd0);
    check("rst busy16", {31'b0, busy16}, 32'd0);

    // W=8 directed vectors
    run_op(8, OP_ADD, 16'd200, 16'd100, 32'd300,    16'd0,  1'b0, 1, 1'b0, "add200+100");
    run_op(8, OP_SUB, 16'd5,   16'd10,  32'hFFFB,   16'd0,  1'b0, 1, 1'b0, "sub5-10");
    run_op(8, OP_SUB, 16'd10,  16'd5,   32'd5,      16'd0,  1'b0, 1, 1'b0, "sub10-5");
    run_op(8, OP_MUL, 16'd255, 16'd255, 32'hFE01,   16'd0,  1'b0, 9, 1'b1, "mul255x255");
    run_op(8, OP_DIV, 16'd200, 16'd7,   32'd28,     16'd4,  1'b0, 9, 1'b0, "div200/7");
    run_op(8, OP_DIV, 16'd13,  16'd0,   32'hFFFF,   16'd13, 1'b1, 1, 1'b0, "div13/0");
    run_op(8, OP_ADD, 16'd255, 16'd255, 32'd510,    16'd0,  1'b0, 1, 1'b0, "add255+255");
    run_op(8, OP_SUB, 16'd0,   16'd255, 32'hFF01,   16'd0,  1'b0, 1, 1'b0, "sub0-255");
    run_op(8, OP_DIV, 16'd5,   16'd9,   32'd0,      16'd5,  1'b0, 9, 1'b0, "div5/9");
    run_op(8, OP_DIV, 16'd255, 16'd1,   32'd255,    16'd0,  1'b0, 9, 1'b0, "div255/1");
    run_op(8, OP_MUL, 16'd13,  16'd0,   32'd0,      16'd0,  1'b0, 9, 1'b0, "mul13x0");

    // reset on the 4th RUN edge of a multiply (S currently holds 0, so load a nonzero first)
    run_op(8, OP_MUL, 16'd12,  16'd11,  32'd132,    16'd0,  1'b0, 9, 1'b0, "mul12x11");
    cur_w = 8;
    drive(8, 1'b1, OP_MUL, 16'd100, 16'd3);
    @(posedge clk); #1;
    drive(8, 1'b0, 2'b00, 16'h0, 16'h0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done = seen_done | done8;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst busy", {31'b0, busy8}, 32'd0);
    check("midrun_rst S", {16'b0, s8}, 32'd0);
    check("midrun_rst R", {24'b0, r8}, 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      seen_done = seen_done | done8;
    end
    check("midrun_rst no_done", {31'b0, seen_done}, 32'd0);
    check("midrun_rst S_hold", {16'b0, s8}, 32'd0);
    run_op(8, OP_ADD, 16'd1, 16'd1, 32'd2, 16'd0, 1'b0, 1, 1'b0, "add1+1_after_rst");

    // W=16 directed
    run_op(16, OP_MUL, 16'hFFFF, 16'd2, 32'd131070, 16'd0, 1'b0, 17, 1'b0, "mul65535x2");
    run_op(16, OP_DIV, 16'hFFFF, 16'hFFFF, 32'd1, 16'd0, 1'b0, 17, 1'b0, "div65535/65535");

    // W=16 random ops against a behavioural model
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rr   = 16'h0;
      rerr = 1'b0;
      rlat = 1;
      case (rop)
        2'b00: rs = 32'(ra) + 32'(rb);
        2'b01: begin
          rd = {1'b0, ra} - {1'b0, rb};
          rs = {{16{rd[16]}}, rd[15:0]};
        end
        2'b10: begin
          rs = 32'(ra) * 32'(rb);
          rlat = 17;
        end
        default: begin
          if (rb == 16'h0) begin
            rs = 32'hFFFF_FFFF;
            rr = ra;
            rerr = 1'b1;
          end else begin
            rs = 32'(ra / rb);
            rr = ra % rb;
            rlat = 17;
          end
        end
      endcase
      run_op(16, rop, ra, rb, rs, rr, rerr, rlat, ($urandom_range(0, 3) == 0), "rand16");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/calculadora_mc.md
# calculadora_mc

Parametrised multi-cycle successor to the 8-bit four-operation calculator, built for wider operands. Performs add, subtract, multiply and divide on W-bit unsigned operands behind a start/busy/done handshake. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) iterate one bit per cycle, so a wide datapath does not need a large combinational multiplier or divider. Outputs are the result, the remainder and a divide-by-zero flag, all held stable until the next operation.

## Interface
- W, default 8: operand width, ≥ 2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only while idle (busy=0).
- op  in  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- A  in  W  operand A.
- B  in  W  operand B (divisor when op=11).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; S, R and err are valid while it is high and afterwards.
- S  out  2W  result, or quotient for divide.
- R  out  W  remainder for divide; 0 for other operations.
- err  out  1  divide by zero on the last operation.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: mul/div iterations.
  - DONE: done=1; always returns to IDLE on the next edge.
- Acceptance: an edge in IDLE with start=1.
  - A, B and op are captured into internal registers at that edge.
  - Later changes on the input pins are ignored until the next acceptance.
- Add: S = zero-extended (A+B), W+1 significant bits. R=0, err=0. Goes directly to DONE.
- Sub: S = {W copies of borrow, (A−B) mod 2^W}, i.e. a two's-complement result sign-extended to 2W. R=0, err=0. Goes directly to DONE.
- Mul: unsigned shift-add.
  - Iteration counter is loaded with W; RUN performs one iteration per edge.
  - S = exact 2W-bit product. R=0.
- Div: unsigned restoring division, W iterations in RUN.
  - S = zero-extended quotient. R = remainder.
- Divide by zero (op=11, B=0): no iteration.
  - Goes directly to DONE with err=1, S = all ones (2W bits), R = captured A.
- S, R and err update only at completion and hold until the next completion or reset.
- start while busy, including in DONE, is ignored; no queueing.

## Timing
- Acceptance is edge k. done is sampled high at:
  - add/sub/div-by-zero: edge k+1 (latency 1);
  - mul/div: edge k+W+1 (latency W+1), with RUN iterations on edges k+1..k+W.
- busy is low before k, high from after edge k until the edge that returns to IDLE, and low in the cycle after done.
- Next acceptance is possible at the edge after done; peak throughput is one add/sub every 2 cycles.
- Reset, whenever rst=1 at an edge:
  - state=IDLE, busy=0, done=0, S=0, R=0, err=0, counter=0;
  - rst has priority over start;
  - reset mid-RUN aborts the operation, no done is issued, and no partial result is exposed.
- The counter width is clog2(W+1). Reaching zero at the final iteration edge enters DONE; there is no wrap-around.

## Structure
- Package calc_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV as a 2-bit enum;
  - the state enum ST_IDLE, ST_RUN, ST_DONE.
- Sub-module mul_div_iter #(W): iterative engine holding the accumulator/partial-remainder and shift registers, with load/step inputs and product/quotient/remainder outputs.
- Top level contains the FSM, the counter, the add/sub datapath, the zero-divisor check and the output registers.

## Test plan
- W=8, add 200+100 → S=300, R=0, err=0, done 1 cycle after accept; busy low the following cycle.
- W=8, sub 5−10 → S=16'hFFFB. Sub 10−5 → S=5.
- W=8, mul 255×255 with start held high throughout → S=16'hFE01, done exactly 9 cycles after accept, one accept only while busy; A/B changed mid-run have no effect.
- W=8, div 200/7 → S=28, R=4, err=0 at latency 9. Then div 13/0 → err=1, S=16'hFFFF, R=13 at latency 1.
- W=8, rst asserted on the 4th RUN edge of a mul → next cycle busy=0, S=0, no done pulse. An add 1+1 accepted immediately after → S=2.
- W=16, mul 65535×2 → S=131070 at latency 17. Then 1000 random ops of every op code (including B=0) are checked against a behavioural model for S, R, err and latency.
